// File: rtl/ddr3_app_pkg.sv
// Shared command codes, burst length and FSM encoding for the DDR3 app-side responder model.
// Pure definitions: no latency and no flow control of their own.
package ddr3_app_pkg;

    localparam logic [2:0] WR_CMD      = 3'd0;
    localparam logic [2:0] RD_CMD      = 3'd1;
    localparam int         BURST_BEATS = 8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR_BURST,
        ST_RD_WAIT,
        ST_RD_BURST
    } state_e;

endpackage

// File: rtl/ddr3_model_ram.sv
// Simple dual-port backing store: one write port, one synchronous read port.
// Read data is valid one cycle after rd_en; no backpressure, the ports are always ready.
module ddr3_model_ram #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_ref,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: contents must survive rst_n.
    always_ff @(posedge clk_ref) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ddr3_app_responder.sv
// Behavioural DDR3 app-interface responder: 8-beat write/read bursts into a local RAM, reads return RD_LATENCY cycles after accept.
// cmd_rdy only in IDLE, wr_rdy in IDLE/WR_BURST; anything offered outside those windows is dropped and flagged in sticky proto_err.
module ddr3_app_responder
    import ddr3_app_pkg::*;
#(
    parameter int DQ_WIDTH    = 16,
    parameter int ADDR_WIDTH  = 27,
    parameter int MEM_BEATS   = 1024,
    parameter int INIT_CYCLES = 100,
    parameter int RD_LATENCY  = 4
) (
    input  logic                    clk_ref,
    input  logic                    rst_n,
    input  logic [2:0]              cmd,
    input  logic                    cmd_en,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [8*DQ_WIDTH-1:0]   wr_data,
    input  logic                    wren,
    input  logic                    wr_end,
    output logic                    init_done,
    output logic                    cmd_rdy,
    output logic                    wr_rdy,
    output logic [8*DQ_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    proto_err
);

    localparam int BW = 8 * DQ_WIDTH;
    localparam int BA = $clog2(MEM_BEATS);
    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int CW = $clog2(RD_LATENCY + 9);

    localparam logic [IW-1:0] INIT_LAST   = IW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] ISSUE_FIRST = CW'(RD_LATENCY - 1);
    localparam logic [CW-1:0] ISSUE_LAST  = CW'(RD_LATENCY + BURST_BEATS - 2);
    localparam logic [CW-1:0] BURST_FIRST = CW'(RD_LATENCY);
    localparam logic [CW-1:0] BURST_DONE  = CW'(RD_LATENCY + BURST_BEATS);
    localparam logic [2:0]    LAST_BEAT   = 3'(BURST_BEATS - 1);

    state_e          state;
    logic [IW-1:0]   init_cnt;
    logic [CW-1:0]   rd_cyc;
    logic [BA-1:0]   wr_ptr;
    logic [BA-1:0]   rd_ptr;
    logic [2:0]      wr_cnt;
    logic            ram_vld;
    logic [BW-1:0]   ram_q;

    logic [BA-1:0]   cmd_beat;
    logic            accept;
    logic            wr_accept;
    logic            rd_accept;
    logic            rd_issue;
    logic            ram_we;
    logic [BA-1:0]   ram_waddr;
    logic            violation;
    logic            unused_addr_bits;

    assign cmd_beat         = addr[3 +: BA];
    assign unused_addr_bits = ^addr[ADDR_WIDTH-1:3+BA];

    assign cmd_rdy   = (state == ST_IDLE);
    assign wr_rdy    = (state == ST_IDLE) || (state == ST_WR_BURST);

    assign accept    = cmd_en && cmd_rdy;
    assign wr_accept = accept && (cmd == WR_CMD);
    assign rd_accept = accept && (cmd == RD_CMD);

    // RAM read for beat j is issued one cycle before it lands in rd_data.
    assign rd_issue  = ((state == ST_RD_WAIT) || (state == ST_RD_BURST)) &&
                       (rd_cyc >= ISSUE_FIRST) && (rd_cyc <= ISSUE_LAST);

    assign ram_we    = (wr_accept && wren) || ((state == ST_WR_BURST) && wren);
    assign ram_waddr = (state == ST_WR_BURST) ? wr_ptr : cmd_beat;

    assign violation = (cmd_en && !cmd_rdy)
                     || (accept && (cmd != WR_CMD) && (cmd != RD_CMD))
                     || (accept && (addr[2:0] != 3'd0))
                     || ((state == ST_IDLE) && wren && !wr_accept)
                     || (wren != wr_end);

    ddr3_model_ram #(
        .WIDTH (BW),
        .DEPTH (MEM_BEATS)
    ) u_ram (
        .clk_ref (clk_ref),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_dat  (wr_data),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_dat  (ram_q)
    );

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            rd_cyc    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_cnt    <= '0;
            ram_vld   <= 1'b0;
            init_done <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (violation) begin
                proto_err <= 1'b1;
            end
            ram_vld  <= rd_issue;
            rd_valid <= ram_vld;
            if (ram_vld) begin
                rd_data <= ram_q;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + BA'(1);
            end

            case (state)
                ST_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + IW'(1);
                    end
                end
                ST_IDLE: begin
                    if (wr_accept) begin
                        state <= ST_WR_BURST;
                        if (wren) begin
                            wr_ptr <= cmd_beat + BA'(1);
                            wr_cnt <= 3'd1;
                        end else begin
                            wr_ptr <= cmd_beat;
                            wr_cnt <= 3'd0;
                        end
                    end else if (rd_accept) begin
                        state  <= ST_RD_WAIT;
                        rd_ptr <= cmd_beat;
                        rd_cyc <= CW'(1);
                    end
                end
                ST_WR_BURST: begin
                    if (wren) begin
                        wr_ptr <= wr_ptr + BA'(1);
                        wr_cnt <= wr_cnt + 3'd1;
                        if (wr_cnt == LAST_BEAT) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    rd_cyc <= rd_cyc + CW'(1);
                    if (rd_cyc == BURST_FIRST) begin
                        state <= ST_RD_BURST;
                    end
                end
                ST_RD_BURST: begin
                    rd_cyc <= rd_cyc + CW'(1);
                    if (rd_cyc == BURST_DONE) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Directed plus randomized bench for ddr3_app_responder against a beat-array reference model.
module tb_ddr3_app_responder;

    localparam int DQ = 16;
    localparam int AW = 27;
    localparam int MB = 1024;
    localparam int IC = 100;
    localparam int RL = 4;
    localparam int BW = 8 * DQ;

    logic            clk_ref = 1'b0;
    logic            rst_n   = 1'b0;
    logic [2:0]      cmd     = 3'd0;
    logic            cmd_en  = 1'b0;
    logic [AW-1:0]   addr    = '0;
    logic [BW-1:0]   wr_data = '0;
    logic            wren    = 1'b0;
    logic            wr_end  = 1'b0;
    logic            init_done, cmd_rdy, wr_rdy, rd_valid, proto_err;
    logic [BW-1:0]   rd_data;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0]   model   [MB];
    bit              written [MB];
    logic [BW-1:0]   last_rd;
    bit              last_known;
    logic            exp_err;
    logic [AW-1:0]   wr_list [$];

    ddr3_app_responder #(
        .DQ_WIDTH    (DQ),
        .ADDR_WIDTH  (AW),
        .MEM_BEATS   (MB),
        .INIT_CYCLES (IC),
        .RD_LATENCY  (RL)
    ) dut (
        .clk_ref   (clk_ref),
        .rst_n     (rst_n),
        .cmd       (cmd),
        .cmd_en    (cmd_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .wren      (wren),
        .wr_end    (wr_end),
        .init_done (init_done),
        .cmd_rdy   (cmd_rdy),
        .wr_rdy    (wr_rdy),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .proto_err (proto_err)
    );

    always #5 clk_ref = ~clk_ref;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_ref);
        #1;
    endtask

    function automatic logic [BW-1:0] rand_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic reset_and_init();
        cmd_en = 1'b0; wren = 1'b0; wr_end = 1'b0; cmd = 3'd0;
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {init_done, cmd_rdy, wr_rdy, rd_valid, proto_err}, 0);
        check("rst_rd_data", rd_data, 0);
        exp_err = 1'b0; last_rd = '0; last_known = 1'b1;
        repeat (3) cyc();
        rst_n = 1'b1;
        for (int k = 1; k <= IC; k++) begin
            cyc();
            if (k < IC) check("init_quiet", {init_done, cmd_rdy, wr_rdy, rd_valid, proto_err}, 0);
            else        check("init_ready", {init_done, cmd_rdy, wr_rdy, proto_err}, 4'b1110);
        end
    endtask

    // seq=1 writes beat k with value k; otherwise random data and random gaps.
    task automatic do_write(input logic [AW-1:0] a, input bit b0, input bit seq, input int maxgap);
        int base;
        int k;
        logic [BW-1:0] d;
        base = int'(a >> 3) % MB;
        k = 0;
        cmd_en = 1'b1; cmd = 3'd0; addr = a;
        if (b0) begin
            d = seq ? BW'(0) : rand_beat();
            wren = 1'b1; wr_end = 1'b1; wr_data = d;
            model[base] = d; written[base] = 1'b1;
            k = 1;
        end
        cyc();
        cmd_en = 1'b0; wren = 1'b0; wr_end = 1'b0;
        if (a[2:0] != 3'd0) exp_err = 1'b1;
        check("wr_busy_rdy", {cmd_rdy, wr_rdy}, 2'b01);
        while (k < 8) begin
            repeat ($urandom_range(maxgap, 0)) cyc();
            d = seq ? BW'(k) : rand_beat();
            wren = 1'b1; wr_end = 1'b1; wr_data = d;
            model[(base + k) % MB] = d; written[(base + k) % MB] = 1'b1;
            k++;
            cyc();
            wren = 1'b0; wr_end = 1'b0;
        end
        check("wr_done_cmd_rdy", cmd_rdy, 1);
        check("wr_proto_err", proto_err, exp_err);
        wr_list.push_back(a);
    endtask

    // inj: cycle offset at which a stray cmd_en is driven; abort_k: return early at that offset.
    task automatic do_read(input logic [AW-1:0] a, input int inj, input int abort_k);
        int base;
        int idx;
        base = int'(a >> 3) % MB;
        cmd_en = 1'b1; cmd = 3'd1; addr = a;
        cyc();
        cmd_en = 1'b0;
        if (a[2:0] != 3'd0) exp_err = 1'b1;
        check("rd_accept_quiet", {rd_valid, cmd_rdy}, 2'b00);
        for (int k = 1; k <= RL + 8; k++) begin
            if (k == inj) begin
                cmd_en = 1'b1; cmd = 3'($urandom_range(7, 0));
            end
            cyc();
            cmd_en = 1'b0;
            if (k == inj) exp_err = 1'b1;
            if (k >= RL && k <= RL + 7) begin
                idx = (base + k - RL) % MB;
                check("rd_valid_on", rd_valid, 1);
                if (written[idx]) begin
                    check("rd_data", rd_data, model[idx]);
                    last_rd = model[idx]; last_known = 1'b1;
                end else begin
                    last_known = 1'b0;
                end
            end else begin
                check("rd_valid_off", rd_valid, 0);
                if (last_known) check("rd_data_hold", rd_data, last_rd);
            end
            check("rd_cmd_rdy", cmd_rdy, (k == RL + 8) ? 1 : 0);
            if (k == abort_k) return;
        end
        check("rd_proto_err", proto_err, exp_err);
    endtask

    initial begin
        logic [AW-1:0] a;
        reset_and_init();

        // Sequential burst at 0x40, then read it back.
        do_write(AW'('h40), 1'b1, 1'b1, 0);
        do_read(AW'('h40), -1, -1);

        // Wrap: prefill beats 0..7, then a burst crossing the top of memory.
        do_write(AW'(0), 1'b0, 1'b0, 1);
        do_write(AW'((MB - 4) * 8), 1'b1, 1'b0, 0);
        do_read(AW'(0), -1, -1);
        do_read(AW'((MB - 4) * 8), -1, -1);

        // Randomized bursts with random gaps.
        for (int i = 0; i < 12; i++) begin
            a = AW'($urandom_range(MB - 1, 0)) << 3;
            do_write(a, 1'($urandom_range(1, 0)), 1'b0, 2);
            do_read(a, -1, -1);
            do_read(wr_list[$urandom_range(wr_list.size() - 1, 0)], -1, -1);
        end

        // Undefined command code is dropped and leaves the FSM in IDLE.
        cmd_en = 1'b1; cmd = 3'd3; addr = AW'('h40);
        cyc();
        cmd_en = 1'b0; exp_err = 1'b1;
        check("badcmd_err", proto_err, 1);
        check("badcmd_idle", {cmd_rdy, wr_rdy}, 2'b11);
        do_read(AW'('h40), -1, -1);

        // Command during a read burst; the burst still completes.
        reset_and_init();
        do_read(AW'('h40), RL + 3, -1);

        // Misaligned address: flagged, low bits ignored.
        reset_and_init();
        do_read(AW'('h41), -1, -1);

        // Stray write beat in IDLE is discarded.
        reset_and_init();
        addr = AW'('h40); wren = 1'b1; wr_end = 1'b1; wr_data = rand_beat();
        cyc();
        wren = 1'b0; wr_end = 1'b0; exp_err = 1'b1;
        check("stray_err", proto_err, 1);
        do_read(AW'('h40), -1, -1);

        // wr_end without wren.
        reset_and_init();
        wr_end = 1'b1;
        cyc();
        wr_end = 1'b0; exp_err = 1'b1;
        check("wr_end_err", proto_err, 1);

        // Reset in the middle of a read burst; memory survives.
        reset_and_init();
        do_read(AW'('h40), -1, RL + 4);
        rst_n = 1'b0;
        #1;
        check("abort_rd_valid", rd_valid, 0);
        check("abort_init_done", init_done, 0);
        reset_and_init();
        do_read(AW'('h40), -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr3_app_responder.md
DDR3_APP_RESPONDER -- requirements
Module: ddr3_app_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_ref (all logic on its rising edge) and rst_n (asynchronous, active-low).
REQ-002 The block SHALL have these parameters:
- DQ_WIDTH, default 16: DRAM data width; beat width is 8*DQ_WIDTH.
- ADDR_WIDTH, default 27: app address width.
- MEM_BEATS, default 1024: backing store depth in beats; power of two.
- INIT_CYCLES, default 100: cycles from reset release to init_done.
- RD_LATENCY, default 4: cycles from read command accept to first rd_valid; minimum 2.
REQ-003 The block SHALL have these ports:
- clk_ref  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd  in  3  command: 0 = write, 1 = read.
- cmd_en  in  1  command strobe.
- addr  in  ADDR_WIDTH  word address.
- wr_data  in  8*DQ_WIDTH  write beat.
- wren  in  1  write beat strobe.
- wr_end  in  1  beat end marker; must equal wren.
- init_done  out  1  model ready.
- cmd_rdy  out  1  command may be accepted.
- wr_rdy  out  1  write beat may be accepted.
- rd_data  out  8*DQ_WIDTH  read beat.
- rd_valid  out  1  rd_data valid.
- proto_err  out  1  sticky protocol violation.

Function
REQ-004 The block SHALL implement the states INIT, IDLE, WR_BURST and RD_WAIT/RD_BURST.
REQ-005 INIT SHALL count INIT_CYCLES cycles after reset release and then enter IDLE; init_done SHALL be 1 from then on.
REQ-006 cmd_rdy SHALL be 1 only in IDLE; wr_rdy SHALL be 1 only in IDLE and in WR_BURST. Both SHALL be decoded combinationally from state.
REQ-007 A command SHALL be accepted when cmd_en && cmd_rdy; cmd_en at any other time SHALL set proto_err and be ignored.
REQ-008 Beat address SHALL be addr[ADDR_WIDTH-1:3] modulo MEM_BEATS; addr[2:0] != 0 at accept SHALL set proto_err, with the low bits ignored.
REQ-009 A cmd value other than 0 or 1 at accept SHALL set proto_err; the command SHALL be dropped and the state SHALL remain IDLE.
REQ-010 Write burst:
- A write accept SHALL enter WR_BURST and latch the base address.
- A beat is accepted on wren && wr_rdy. A beat in the accept cycle itself is beat 0.
- Beat k SHALL be stored at base+k (modulo MEM_BEATS); k = 0..7.
- After beat 7 the state SHALL return to IDLE, so cmd_rdy=1 the next cycle.
REQ-011 wren in IDLE without a write accept in the same cycle SHALL set proto_err and the data SHALL be discarded.
REQ-012 wren != wr_end in any cycle SHALL set proto_err; wren alone SHALL qualify the beat.
REQ-013 Read burst:
- A read accepted at cycle T SHALL produce rd_valid=1 at cycles T+RD_LATENCY .. T+RD_LATENCY+7, contiguous.
- rd_data SHALL carry beats base+0 .. base+7, registered.
- The state SHALL return to IDLE at T+RD_LATENCY+8.
REQ-014 A write beat stored at cycle U SHALL be visible to a read accepted at U+1 or later; read-after-write at the same address SHALL return the new data.
REQ-015 In every cycle where rd_valid=0, rd_data SHALL hold its last value.
REQ-016 proto_err SHALL be sticky until reset. A violation SHALL NOT abort a burst in progress.
REQ-017 Address wrap: a burst crossing MEM_BEATS-1 SHALL continue at beat 0.

Reset
REQ-018 Asserting rst_n low SHALL asynchronously clear the outputs to: init_done=0, cmd_rdy=0, wr_rdy=0, rd_valid=0, rd_data=0, proto_err=0.
REQ-019 Asserting rst_n low SHALL abort any burst in progress, reset all state and counters, and restart the INIT countdown.
REQ-020 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-021 Package ddr3_app_pkg SHALL hold:
- command codes WR_CMD=0 and RD_CMD=1;
- BURST_BEATS=8;
- the state encoding.
REQ-022 Backing store SHALL be one sub-module, ddr3_model_ram: simple dual-port RAM, 8*DQ_WIDTH x MEM_BEATS, one write port and one synchronous read port with 1-cycle read latency.

Verification
REQ-023 Init scenario: release reset, INIT_CYCLES=100 -> init_done=1, cmd_rdy=1 and wr_rdy=1 at cycle 100; all outputs 0 before that.
REQ-024 Write/read scenario:
- Stimulus: write at addr 0x40 with beat 0 in the accept cycle, beats 0x0..0x7 in consecutive cycles; then read at 0x40.
- Response: rd_valid for 8 cycles starting RD_LATENCY=4 after accept, data 0x0..0x7, proto_err=0.
REQ-025 Wrap scenario: write at addr (MEM_BEATS-4)*8 with 8 beats, then read at addr 0 -> beats 4..7 of that burst appear as rd_data beats 0..3.
REQ-026 Violation scenario: each of cmd=3 in IDLE, cmd_en during RD_BURST, and addr=0x41 -> proto_err=1 and stays 1; the burst in flight still completes all 8 beats.
REQ-027 Stray beat scenario: wren=1 in IDLE with cmd_en=0 -> proto_err=1; a later read of the addressed beats returns the old data.
REQ-028 Reset scenario: rst_n low at beat 4 of a read burst -> rd_valid=0 immediately, init_done=0; after INIT_CYCLES, previously written data is still readable.
